output_argmax_scorer: RTL and testbench
=======================================

// Module: output_argmax_scorer
// PURPOSE
//  Downstream of the SNN output layer: consumes one image's NUM_CLASSES output-neuron voltages, streamed serially.
//  Picks the winning class (argmax) and compares it with the true label.
//  Keeps running image/correct counters, so accuracy comes from hardware rather than probing fp[] hierarchically.
// PARAMETERS
//  NUM_CLASSES  10  output neurons per image (index 0..NUM_CLASSES-1)
//  VOLT_W       14  signed two's-complement width of one neuron voltage
//  CNT_W        16  width of img_count / correct_count
// PORTS
//  clk            in   1        rising-edge clock
//  reset          in   1        asynchronous, active-high reset
//  clear_stats    in   1        sync pulse: zero img_count/correct_count
//  v_valid        in   1        voltage beat valid
//  v_ready        out  1        scorer can accept a voltage beat
//  v_data         in   VOLT_W   signed voltage of neuron at current beat index
//  label_valid    in   1        true-label valid (one per image)
//  label          in   4        true label; values >= NUM_CLASSES are invalid
//  res_valid      out  1        result valid; held until accepted
//  res_ready      in   1        consumer accepts result
//  guess          out  4        argmax index
//  correct        out  1        guess == latched label and label valid
//  img_count      out  CNT_W    images scored since reset/clear
//  correct_count  out  CNT_W    correctly scored images
// BEHAVIOUR
//  - Reset: state COLLECT, beat index 0, label_held 0, all outputs 0 except v_ready=1.
//  - Beat transfer = v_valid & v_ready; beat k carries neuron k. k counts 0..NUM_CLASSES-1 internally; there is no last flag.
//  - Beat 0 loads best=v_data, guess=0 unconditionally. Beat k>0 replaces best only if $signed(v_data) > best (strict).
//  - Ties resolve to the lowest index.
//  - Label: label_valid is latched whenever no label is held, in any state except RESULT.
//    A second label_valid while one is held is ignored.
//  - FSM:
//    COLLECT: v_ready=1. After the last beat -> WAIT_LABEL, or straight to RESULT if a label is held or arriving that cycle.
//    WAIT_LABEL: v_ready=0. Label arrival -> RESULT.
//    RESULT: v_ready=0, res_valid=1. guess and correct are stable until res_ready.
//      On res_ready: update counters, clear label_held and index, -> COLLECT.
//  - Latency: res_valid rises 1 cycle after the later of last-beat transfer and label capture.
//  - Counters saturate at 2^CNT_W-1 and never wrap; correct_count <= img_count always.
//  - clear_stats takes priority over an accept in the same cycle: counters go to 0 and the accepted image is not counted.
//  - Label >= NUM_CLASSES: correct=0; the image still counts in img_count.
//  - Reset mid-image discards partial best/index/label.
// CONFIGURATION
//  ARGMAX_MARGIN_EN defined: adds output margin [VOLT_W:0] = best - second_best (unsigned, computed at VOLT_W+1 bits).
//    margin is valid with res_valid. A tie gives 0. second_best initialises at beat 1.
//    A beat equal to best goes to second_best.
//  Undefined: no margin port, no second_best register; all other behaviour identical.
// STRUCTURE
//  Package snn_out_pkg: NUM_CLASSES/VOLT_W defaults, label_t (4-bit), state enum {COLLECT, WAIT_LABEL, RESULT}.
//  Sub-module argmax_track: holds best/index (and second_best under ARGMAX_MARGIN_EN), with load/update inputs.
//  The top level keeps the FSM, label latch and counters.
// TESTING
//  1 Voltages 5,-3,100,7,0,0,0,0,0,-8192, label=2 -> guess=2, correct=1, img_count=1, correct_count=1.
//  2 Voltages all -8192, label=0 -> guess=0 (lowest index wins, all values equal).
//    Under ARGMAX_MARGIN_EN -> margin=0.
//  3 Label sent before beat 0; res_ready low 5 cycles -> res_valid/guess held, v_ready=0, no count.
//    Then accept -> counts +1.
//  4 Label=12, any voltages -> correct=0, img_count+1, correct_count unchanged.
//  5 Force counters to 0xFFFE, score 3 correct images -> both saturate at 0xFFFF.
//    clear_stats together with res_ready -> both 0.
//  6 Reset asserted after beat 4, then a full new image (max at 9, label 9) -> guess=9, correct=1, img_count=1.

Source files
------------

// File: rtl/output_argmax_scorer_pkg.sv
// Shared defaults, label type and scorer FSM states for the SNN output-layer scorer.
package snn_out_pkg;
  localparam int DEF_NUM_CLASSES = 10;
  localparam int DEF_VOLT_W      = 14;
  localparam int DEF_CNT_W       = 16;

  typedef logic [3:0] label_t;

  typedef enum logic [1:0] {
    COLLECT    = 2'd0,
    WAIT_LABEL = 2'd1,
    RESULT     = 2'd2
  } state_t;
endpackage

// File: rtl/output_argmax_scorer_track.sv
// Running argmax over serial voltage beats; lowest index wins ties. Latency 1 cycle, no backpressure.
// ARGMAX_MARGIN_EN adds a second_best register and a best - second_best margin output.
module argmax_track #(
  parameter int VOLT_W = 14,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              update,
  input  logic [IDX_W-1:0]  idx,
  input  logic [VOLT_W-1:0] v_data,
  output logic [IDX_W-1:0]  best_idx
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic [VOLT_W:0]   margin
`endif
);
  logic signed [VOLT_W-1:0] vin;
  logic signed [VOLT_W-1:0] best_q, best_d;
  logic [IDX_W-1:0]         idx_q, idx_d;

  assign vin      = $signed(v_data);
  assign best_idx = idx_q;

  always_comb begin
    best_d = best_q;
    idx_d  = idx_q;
    if (load) begin
      best_d = vin;
      idx_d  = '0;
    end else if (update && (vin > best_q)) begin
      best_d = vin;
      idx_d  = idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_q <= '0;
      idx_q  <= '0;
    end else begin
      best_q <= best_d;
      idx_q  <= idx_d;
    end
  end

`ifdef ARGMAX_MARGIN_EN
  logic signed [VOLT_W-1:0] sec_q, sec_d;
  logic                     sec_vld_q, sec_vld_d;

  // A beat that does not beat best (including a tie) competes for second place.
  always_comb begin
    sec_d     = sec_q;
    sec_vld_d = sec_vld_q;
    if (load) begin
      sec_vld_d = 1'b0;
    end else if (update) begin
      sec_vld_d = 1'b1;
      if (vin > best_q) begin
        sec_d = best_q;
      end else if (!sec_vld_q || (vin > sec_q)) begin
        sec_d = vin;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_q     <= '0;
      sec_vld_q <= 1'b0;
    end else begin
      sec_q     <= sec_d;
      sec_vld_q <= sec_vld_d;
    end
  end

  assign margin = {best_q[VOLT_W-1], best_q} - {sec_q[VOLT_W-1], sec_q};
`endif
endmodule

// File: rtl/output_argmax_scorer.sv
// Scores one image of serial output-neuron voltages (argmax vs label) and keeps saturating counters.
// res_valid 1 cycle after later of last beat/label; v_ready low until result accepted. ARGMAX_MARGIN_EN adds margin.
module output_argmax_scorer
  import snn_out_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int VOLT_W      = DEF_VOLT_W,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_stats,
  input  logic              v_valid,
  output logic              v_ready,
  input  logic [VOLT_W-1:0] v_data,
  input  logic              label_valid,
  input  label_t            label,
  output logic              res_valid,
  input  logic              res_ready,
  output label_t            guess,
  output logic              correct,
  output logic [CNT_W-1:0]  img_count,
  output logic [CNT_W-1:0]  correct_count
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic [VOLT_W:0]   margin
`endif
);
  localparam label_t           LAST_IDX = label_t'(NUM_CLASSES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  label_t           idx_q, idx_d;
  label_t           label_q, label_d;
  logic             label_held_q, label_held_d;
  logic [CNT_W-1:0] img_q, img_d;
  logic [CNT_W-1:0] corr_q, corr_d;

  logic beat, last_beat, label_take, accept, label_ok;

  assign v_ready    = (state_q == COLLECT);
  assign res_valid  = (state_q == RESULT);
  assign beat       = v_valid & v_ready;
  assign last_beat  = beat && (idx_q == LAST_IDX);
  assign label_take = label_valid && !label_held_q && (state_q != RESULT);
  assign accept     = res_valid && res_ready;
  assign label_ok   = ({1'b0, label_q} < 5'(NUM_CLASSES));
  assign correct    = res_valid && label_held_q && label_ok && (guess == label_q);

  assign img_count     = img_q;
  assign correct_count = corr_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    label_d      = label_q;
    label_held_d = label_held_q;
    if (label_take) begin
      label_d      = label;
      label_held_d = 1'b1;
    end
    case (state_q)
      COLLECT: begin
        if (beat) begin
          idx_d = last_beat ? '0 : idx_q + label_t'(1);
          if (last_beat) begin
            state_d = (label_held_q || label_take) ? RESULT : WAIT_LABEL;
          end
        end
      end
      WAIT_LABEL: begin
        if (label_take) begin
          state_d = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          label_held_d = 1'b0;
          idx_d        = '0;
          state_d      = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Clear wins over a same-cycle accept, so that image is never counted.
  always_comb begin
    img_d  = img_q;
    corr_d = corr_q;
    if (clear_stats) begin
      img_d  = '0;
      corr_d = '0;
    end else if (accept) begin
      if (img_q != CNT_MAX) begin
        img_d = img_q + CNT_W'(1);
      end
      if (correct && (corr_q != CNT_MAX)) begin
        corr_d = corr_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= COLLECT;
      idx_q        <= '0;
      label_q      <= '0;
      label_held_q <= 1'b0;
      img_q        <= '0;
      corr_q       <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      label_q      <= label_d;
      label_held_q <= label_held_d;
      img_q        <= img_d;
      corr_q       <= corr_d;
    end
  end

  argmax_track #(
    .VOLT_W (VOLT_W),
    .IDX_W  (4)
  ) u_track (
    .clk      (clk),
    .rst      (reset),
    .load     (beat && (idx_q == '0)),
    .update   (beat && (idx_q != '0)),
    .idx      (idx_q),
    .v_data   (v_data),
    .best_idx (guess)
`ifdef ARGMAX_MARGIN_EN
    ,
    .margin   (margin)
`endif
  );
endmodule

// File: tb/tb_output_argmax_scorer.sv
// Scoreboard bench for output_argmax_scorer: random images scored by a plain argmax/accuracy model.
// CNT_W is reduced so counter saturation is reachable in a short run.
module tb_output_argmax_scorer;
  localparam int NC   = 10;
  localparam int VW   = 14;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, clear_stats, v_valid, v_ready, label_valid;
  logic          res_valid, res_ready, correct;
  logic [VW-1:0] v_data;
  logic [3:0]    label, guess;
  logic [CW-1:0] img_count, correct_count;
`ifdef ARGMAX_MARGIN_EN
  logic [VW:0]   margin;
`endif

  output_argmax_scorer #(
    .NUM_CLASSES (NC),
    .VOLT_W      (VW),
    .CNT_W       (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clear_stats   (clear_stats),
    .v_valid       (v_valid),
    .v_ready       (v_ready),
    .v_data        (v_data),
    .label_valid   (label_valid),
    .label         (label),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .guess         (guess),
    .correct       (correct),
    .img_count     (img_count),
    .correct_count (correct_count)
`ifdef ARGMAX_MARGIN_EN
    ,
    .margin        (margin)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int guess;
    int correct;
    int img;
    int corr;
    int margin;
  } exp_t;

  exp_t expq[$];
  exp_t cur;
  bit   have_cur;
  bit   prev_vld;
  int   tests = 0;
  int   fails = 0;
  int   m_img, m_corr;
  int   vbuf[NC];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_argmax();
    int bi = 0;
    for (int k = 1; k < NC; k++) if (vbuf[k] > vbuf[bi]) bi = k;
    return bi;
  endfunction

  task automatic rand_volts();
    int mode = int'($urandom_range(0, 2));
    for (int k = 0; k < NC; k++) begin
      case (mode)
        0:       vbuf[k] = int'($urandom_range(0, 16383)) - 8192;
        1:       vbuf[k] = int'($urandom_range(0, 4)) - 2;
        default: vbuf[k] = ($urandom_range(0, 1) == 1) ? 8191 : -8192;
      endcase
    end
  endtask

  // lbl_at: -1 label before beat 0, 0..NC-1 with that beat, NC after all beats.
  task automatic send_image(input int lbl, input int lbl_at, input int hold, input bit clr, input bit dup);
    exp_t e;
    int   bi, sec, waitc;
    bi  = ref_argmax();
    sec = -100000;
    for (int k = 0; k < NC; k++) if (k != bi && vbuf[k] > sec) sec = vbuf[k];
    e.guess   = bi;
    e.correct = (lbl < NC && lbl == bi) ? 1 : 0;
    e.img     = m_img;
    e.corr    = m_corr;
    e.margin  = vbuf[bi] - sec;
    expq.push_back(e);

    if (lbl_at < 0) begin
      label_valid = 1'b1;
      label       = 4'(lbl);
      tick();
      label_valid = 1'b0;
    end
    for (int k = 0; k < NC; k++) begin
      if ($urandom_range(0, 3) == 0) tick();
      v_valid = 1'b1;
      v_data  = VW'(vbuf[k]);
      if (lbl_at == k) begin
        label_valid = 1'b1;
        label       = 4'(lbl);
      end else if (dup && k == 3) begin
        label_valid = 1'b1;
        label       = 4'(lbl ^ 1);
      end
      waitc = 0;
      while (!v_ready && waitc < 20) begin
        tick();
        waitc++;
      end
      check("v_ready_beat", int'(v_ready), 1);
      tick();
      v_valid     = 1'b0;
      label_valid = 1'b0;
    end
    if (lbl_at >= NC) begin
      tick();
      tick();
      check("wait_label_res_valid", int'(res_valid), 0);
      check("wait_label_v_ready", int'(v_ready), 0);
      label_valid = 1'b1;
      label       = 4'(lbl);
      tick();
      label_valid = 1'b0;
    end
    check("latency", int'(res_valid), 1);
    waitc = 0;
    while (!res_valid && waitc < 20) begin
      tick();
      waitc++;
    end
    repeat (hold) tick();
    res_ready   = 1'b1;
    clear_stats = clr;
    tick();
    res_ready   = 1'b0;
    clear_stats = 1'b0;
    if (clr) begin
      m_img  = 0;
      m_corr = 0;
    end else begin
      if (m_img < CMAX) m_img++;
      if (e.correct == 1 && m_corr < CMAX) m_corr++;
    end
    check("img_count_after", int'(img_count), m_img);
    check("correct_count_after", int'(correct_count), m_corr);
    check("res_valid_dropped", int'(res_valid), 0);
  endtask

  // Monitor: pops one expectation per result and checks it for every cycle the result is held.
  always @(negedge clk) begin
    if (reset) begin
      prev_vld = 1'b0;
      have_cur = 1'b0;
    end else begin
      if (res_valid) begin
        if (!prev_vld) begin
          check("result_expected", int'(expq.size() > 0), 1);
          have_cur = (expq.size() > 0);
          if (have_cur) cur = expq.pop_front();
        end
        if (have_cur) begin
          check("guess", int'(guess), cur.guess);
          check("correct", int'(correct), cur.correct);
          check("img_count_held", int'(img_count), cur.img);
          check("correct_count_held", int'(correct_count), cur.corr);
`ifdef ARGMAX_MARGIN_EN
          check("margin", int'(margin), cur.margin);
`endif
        end
        check("v_ready_in_result", int'(v_ready), 0);
      end
      prev_vld = res_valid;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lbl, lbl_at;
    reset       = 1'b1;
    clear_stats = 1'b0;
    v_valid     = 1'b0;
    v_data      = '0;
    label_valid = 1'b0;
    label       = '0;
    res_ready   = 1'b0;
    m_img       = 0;
    m_corr      = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_v_ready", int'(v_ready), 1);
    check("reset_res_valid", int'(res_valid), 0);
    check("reset_guess", int'(guess), 0);
    check("reset_correct", int'(correct), 0);
    check("reset_img_count", int'(img_count), 0);
    check("reset_correct_count", int'(correct_count), 0);
    reset = 1'b0;
    tick();

    vbuf = '{5, -3, 100, 7, 0, 0, 0, 0, 0, -8192};
    send_image(2, NC, 1, 1'b0, 1'b0);

    for (int k = 0; k < NC; k++) vbuf[k] = -8192;
    send_image(0, 5, 0, 1'b0, 1'b0);

    rand_volts();
    send_image(ref_argmax(), -1, 5, 1'b0, 1'b1);

    rand_volts();
    send_image(12, NC - 1, 2, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      rand_volts();
      lbl    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : ref_argmax();
      lbl_at = int'($urandom_range(0, NC + 1)) - 1;
      send_image(lbl, lbl_at, int'($urandom_range(0, 3)), 1'b0, bit'(lbl_at < 3));
    end

    // Reset in the middle of an image with a label already held.
    label_valid = 1'b1;
    label       = 4'd3;
    tick();
    label_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      v_valid = 1'b1;
      v_data  = VW'(8000 - k);
      tick();
    end
    v_valid = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    check("midreset_v_ready", int'(v_ready), 1);
    check("midreset_res_valid", int'(res_valid), 0);
    check("midreset_img_count", int'(img_count), 0);
    #1;
    reset  = 1'b0;
    m_img  = 0;
    m_corr = 0;
    tick();
    for (int k = 0; k < NC; k++) vbuf[k] = int'($urandom_range(0, 200)) - 100;
    vbuf[9] = 5000;
    send_image(9, NC, 1, 1'b0, 1'b0);
    check("midreset_img_after", int'(img_count), 1);

    // Saturation, then clear together with an accept.
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    m_img  = 0;
    m_corr = 0;
    check("clear_img", int'(img_count), 0);
    check("clear_corr", int'(correct_count), 0);
    for (int i = 0; i < 35; i++) begin
      rand_volts();
      send_image((i < 3) ? 12 : ref_argmax(), int'($urandom_range(0, NC + 1)) - 1, 0, 1'b0, 1'b0);
    end
    check("sat_img", int'(img_count), CMAX);
    check("sat_corr", int'(correct_count), CMAX);
    rand_volts();
    send_image(ref_argmax(), 2, 1, 1'b1, 1'b0);
    check("clear_with_accept_img", int'(img_count), 0);
    check("clear_with_accept_corr", int'(correct_count), 0);

    repeat (3) tick();
    check("scoreboard_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
